// File: rtl/lsu_sequencer_if.sv
// Data-memory port of the load/store sequencer: valid/ready request channel
// plus a separate rvalid read-response channel.
interface lsu_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // Sequencer side: drives the request, receives the handshake and read data.
    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    // Memory side.
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: takes one memory op from execute, stalls the pipe,
// runs it over the data-memory port and returns aligned/extended load data.
// Misaligned, illegal and timed-out accesses finish with a fault instead of hanging.
module lsu_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic              op_load,
    input  logic              op_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] load_result,
    output logic              fault,
    output logic [1:0]        fault_cause,
    lsu_sequencer_if.master   mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              is_store_q, is_store_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept, illegal, misaligned, timed_out;

    assign accept     = op_valid && (op_load || op_store);
    assign illegal    = (op_load && op_store)
                     || (op_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
                     || (op_store && funct3 > 3'b010);
    assign misaligned = (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
                     || (funct3[1:0] == 2'b01 && addr[0]);
    assign timed_out  = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Pick the addressed lane out of the read word and sign/zero extend it.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w,
                                                  input logic [1:0]        lane,
                                                  input logic [2:0]        f3);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'b0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'b0, h};
            default: r = w;
        endcase
        extract = r;
    endfunction

    // State and captured-op registers; reset abandons any in-flight access.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            f3_q       <= '0;
            is_store_q <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            result_q   <= '0;
            cause_q    <= CAUSE_NONE;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            is_store_q <= is_store_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            result_q   <= result_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and output decode; bus fields only leave the block while in REQ.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        f3_d          = f3_q;
        is_store_d    = is_store_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        result_d      = result_q;
        cause_d       = cause_q;
        cnt_d         = cnt_q;
        stall         = 1'b0;
        done          = 1'b0;
        load_result   = '0;
        fault         = 1'b0;
        fault_cause   = CAUSE_NONE;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_be    = '0;
        mem.mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    addr_d     = addr;
                    f3_d       = funct3;
                    is_store_d = op_store;
                    result_d   = '0;
                    cnt_d      = '0;
                    be_d       = 4'b1111;
                    wdata_d    = '0;
                    if (op_store) begin
                        case (funct3[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << addr[1:0];
                                wdata_d = {4{store_data[7:0]}};
                            end
                            2'b01: begin
                                be_d    = 4'b0011 << {addr[1], 1'b0};
                                wdata_d = {2{store_data[15:0]}};
                            end
                            default: wdata_d = store_data;
                        endcase
                    end
                    if (illegal) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = S_DONE;
                    end else if (misaligned) begin
                        cause_d = CAUSE_MISALIGN;
                        state_d = S_DONE;
                    end else begin
                        cause_d = CAUSE_NONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = is_store_q;
                mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem.mem_be    = be_q;
                mem.mem_wdata = wdata_q;
                if (mem.mem_ready) begin
                    if (is_store_q) begin
                        state_d = S_DONE;
                    end else if (mem.mem_rvalid) begin
                        result_d = extract(mem.mem_rdata, addr_q[1:0], f3_q);
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end else if (timed_out) begin
                    cause_d  = CAUSE_TIMEOUT;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem.mem_rvalid) begin
                    result_d = extract(mem.mem_rdata, addr_q[1:0], f3_q);
                    state_d  = S_DONE;
                end else if (timed_out) begin
                    cause_d  = CAUSE_TIMEOUT;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done        = 1'b1;
                load_result = result_q;
                fault       = (cause_q != CAUSE_NONE);
                fault_cause = cause_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: each directed op is expanded by a behavioural model
// into a per-cycle timeline of expected outputs, which a compare thread checks
// every cycle; literal latency/result checks pin the model.
module tb_lsu_sequencer;

    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_load, op_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, done, fault;
    logic [31:0] load_result;
    logic [1:0]  fault_cause;

    lsu_sequencer_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    lsu_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_load     (op_load),
        .op_store    (op_store),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .stall       (stall),
        .done        (done),
        .load_result (load_result),
        .fault       (fault),
        .fault_cause (fault_cause),
        .mem         (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        opv, ready, rvalid;
        logic        stall, req, we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        done;
        logic [31:0] result;
        logic        fault;
        logic [1:0]  cause;
    } cyc_t;

    cyc_t        exp_c;
    logic        exp_valid = 1'b0;
    string       exp_name  = "";
    int          cur_k     = 0;
    int          last_done_k;
    logic [31:0] last_result;
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic string fld(input string f);
        return $sformatf("%s[%0d].%s", exp_name, cur_k, f);
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] model_cause(input logic ld, input logic st,
                                               input logic [2:0] f3, input logic [31:0] a);
        int width;
        if (ld && st) return 2'b10;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b10;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 2'b10;
        width = 1 << f3[1:0];
        if ((int'(a[1:0]) % width) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int width;
        if (!st) return 4'hF;
        width = 1 << f3[1:0];
        return 4'(((1 << width) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return 32'(d[7:0]) * 32'h0101_0101;
            2'b01:   return 32'(d[15:0]) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * a[1:0]);
        case (f3)
            3'd0:    return 32'($signed(sh[7:0]));
            3'd4:    return 32'(sh[7:0]);
            3'd1:    return 32'($signed(sh[15:0]));
            3'd5:    return 32'(sh[15:0]);
            default: return rd;
        endcase
    endfunction

    // rdy_dly: REQ cycles before ready rises (then held); rv_dly: cycles after the
    // ready cycle until the one-cycle rvalid pulse (0 = same cycle).
    task automatic run_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int rdy_dly, input int rv_dly);
        cyc_t tl[$];
        cyc_t z, c, r, d;
        logic [1:0] cause;
        int n_req, n_wait;
        z = '{default: '0};
        cause = model_cause(ld, st, f3, a);
        c = z; c.opv = 1'b1; c.stall = 1'b1;
        tl.push_back(c);
        d = z; d.done = 1'b1;
        if (cause != 2'b00) begin
            d.fault = 1'b1; d.cause = cause;
        end else begin
            r = z; r.stall = 1'b1; r.req = 1'b1; r.we = st;
            r.addr = a & ~32'd3; r.be = model_be(st, f3, a);
            r.wdata = model_wdata(f3, sd);
            n_req = (rdy_dly < TO) ? rdy_dly + 1 : TO;
            for (int i = 0; i < n_req; i++) begin
                c = r;
                c.ready  = (i >= rdy_dly);
                c.rvalid = !st && (i == rdy_dly) && (rv_dly == 0);
                tl.push_back(c);
            end
            if (rdy_dly >= TO) begin
                d.fault = 1'b1; d.cause = 2'b11;
            end else if (!st) begin
                if (rv_dly != 0) begin
                    n_wait = (rv_dly - 1 < TO) ? rv_dly : TO;
                    for (int i = 0; i < n_wait; i++) begin
                        c = z; c.stall = 1'b1; c.ready = 1'b1;
                        c.rvalid = (i == rv_dly - 1);
                        tl.push_back(c);
                    end
                end
                if (rv_dly - 1 >= TO) begin
                    d.fault = 1'b1; d.cause = 2'b11;
                end else begin
                    d.result = model_load(f3, a, rd);
                end
            end
        end
        tl.push_back(d);
        tl.push_back(z);

        last_done_k = -1;
        for (int i = 0; i < tl.size(); i++) begin
            @(posedge clk); #1;
            c = tl[i];
            op_valid = c.opv;
            if (c.opv) begin
                op_load = ld; op_store = st; funct3 = f3; addr = a; store_data = sd;
            end else begin
                op_load = 1'b0; op_store = 1'b0; funct3 = ~f3; addr = ~a; store_data = ~sd;
            end
            mem_if.mem_ready  = c.ready;
            mem_if.mem_rvalid = c.rvalid;
            mem_if.mem_rdata  = c.rvalid ? rd : ~rd;
            exp_c = c; cur_k = i; exp_name = nm; exp_valid = 1'b1;
        end
        @(posedge clk); #1;
        exp_valid = 1'b0;
        mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0;
    endtask

    // Per-cycle comparison of the DUT against the current timeline entry.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (exp_valid) begin
                check(fld("stall"),   32'(stall),          32'(exp_c.stall));
                check(fld("mem_req"), 32'(mem_if.mem_req), 32'(exp_c.req));
                check(fld("done"),    32'(done),           32'(exp_c.done));
                if (exp_c.req) begin
                    check(fld("mem_we"),   32'(mem_if.mem_we), 32'(exp_c.we));
                    check(fld("mem_addr"), mem_if.mem_addr,    exp_c.addr);
                    check(fld("mem_be"),   32'(mem_if.mem_be), 32'(exp_c.be));
                    if (exp_c.we) check(fld("mem_wdata"), mem_if.mem_wdata, exp_c.wdata);
                end
                if (exp_c.done) begin
                    check(fld("load_result"), load_result,       exp_c.result);
                    check(fld("fault"),       32'(fault),        32'(exp_c.fault));
                    check(fld("fault_cause"), 32'(fault_cause),  32'(exp_c.cause));
                end
                if (done === 1'b1) begin
                    last_done_k = cur_k;
                    last_result = load_result;
                end
            end
        end
    endtask

    initial begin
        fork
            compare_loop();
        join_none
        rst_n = 1'b0;
        op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
        funct3 = '0; addr = '0; store_data = '0;
        mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;

        #12;
        check("reset.stall",       32'(stall),            0);
        check("reset.done",        32'(done),             0);
        check("reset.load_result", load_result,           0);
        check("reset.fault",       32'(fault),            0);
        check("reset.fault_cause", 32'(fault_cause),      0);
        check("reset.mem_req",     32'(mem_if.mem_req),   0);
        check("reset.mem_we",      32'(mem_if.mem_we),    0);
        check("reset.mem_addr",    mem_if.mem_addr,       0);
        check("reset.mem_be",      32'(mem_if.mem_be),    0);
        check("reset.mem_wdata",   mem_if.mem_wdata,      0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_op("lb",     1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0);
        check("lb.latency", 32'(last_done_k), 2);
        check("lb.value",   last_result, 32'hFFFF_FF80);
        run_op("lhu",    1, 0, 3'b101, 32'h2002, 32'h0, 32'h8001_0000, 0, 3);
        check("lhu.latency", 32'(last_done_k), 5);
        check("lhu.value",   last_result, 32'h0000_8001);
        run_op("sh",     0, 1, 3'b001, 32'h10, 32'hDEAD_BEEF, 32'h0, 2, 0);
        check("sh.latency", 32'(last_done_k), 4);
        run_op("lw_mis", 1, 0, 3'b010, 32'h6, 32'h0, 32'h0, 0, 0);
        check("lw_mis.latency", 32'(last_done_k), 1);
        run_op("ld_st",  1, 1, 3'b010, 32'h8, 32'h0, 32'h0, 0, 0);
        run_op("sb",     0, 1, 3'b000, 32'h13, 32'h0000_00AB, 32'h0, 0, 0);
        run_op("lh",     1, 0, 3'b001, 32'h2, 32'h0, 32'h8001_7FFF, 1, 1);
        check("lh.value", last_result, 32'hFFFF_8001);
        run_op("lbu",    1, 0, 3'b100, 32'h1, 32'h0, 32'h0000_C300, 0, 0);
        check("lbu.value", last_result, 32'h0000_00C3);
        run_op("lw",     1, 0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 0, 1);
        run_op("sh_mis", 0, 1, 3'b001, 32'h11, 32'h1234, 32'h0, 0, 0);
        run_op("sw_ill", 0, 1, 3'b011, 32'h0, 32'h1, 32'h0, 0, 0);
        run_op("ld_ill", 1, 0, 3'b110, 32'h0, 32'h0, 32'h0, 0, 0);
        run_op("ld_to",  1, 0, 3'b010, 32'h100, 32'h0, 32'h1111_2222, 0, NEVER);
        check("ld_to.latency", 32'(last_done_k), 18);
        check("ld_to.value",   last_result, 32'h0);
        run_op("st_to",  0, 1, 3'b010, 32'h104, 32'h5, 32'h0, NEVER, 0);
        check("st_to.latency", 32'(last_done_k), 17);

        // Reset while a load sits in WAIT.
        @(posedge clk); #1;
        op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(posedge clk); #1;
        op_valid = 1'b0; op_load = 1'b0; mem_if.mem_ready = 1'b1;
        check("rst_mid.req_in_req", 32'(mem_if.mem_req), 1);
        @(posedge clk); #1;
        mem_if.mem_ready = 1'b0;
        check("rst_mid.stall_in_wait", 32'(stall), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.mem_req", 32'(mem_if.mem_req), 0);
        check("rst_mid.stall",   32'(stall),          0);
        check("rst_mid.done",    32'(done),           0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold.done",  32'(done),  0);
            check("rst_hold.stall", 32'(stall), 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        run_op("sw_after_rst", 0, 1, 3'b010, 32'h20, 32'h1234_5678, 32'h0, 0, 0);
        check("sw_after_rst.latency", 32'(last_done_k), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
- Sequences a single load or store from the execute stage onto the data-memory port using a valid/ready request and an rvalid response.
- Decodes funct3 into byte enables and lane-replicated write data, and aligns and sign- or zero-extends returned load data.
- Stalls the pipeline until the access completes.
- Detects misaligned, illegal and timed-out accesses and reports them as faults instead of hanging.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width (fixed 32; byte lanes = 4)
TIMEOUT, 16, max cycles spent in REQ or WAIT before a timeout fault

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  memory op presented by execute stage
op_load  in  1  op is a load
op_store  in  1  op is a store
funct3  in  3  RISC-V width/sign field
addr  in  ADDR_W  effective byte address
store_data  in  32  rs2 value
stall  out  1  hold pipeline
done  out  1  one-cycle completion pulse
load_result  out  32  extended load data, valid with done
fault  out  1  with done: access faulted
fault_cause  out  2  01 misaligned, 10 illegal, 11 timeout
mem_req  out  1  request valid
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated write data
mem_ready  in  1  memory accepts request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data word

Behaviour:
- Reset (async, rst_n low): state IDLE, timeout counter 0. All outputs 0: stall, done, load_result, fault, fault_cause, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- Reset mid-operation: mem_req drops immediately, no done is produced, and the in-flight op is abandoned.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Accept when op_valid & (op_load | op_store).
  - Register addr, funct3, op type and store_data.
  - stall is combinationally high in the accept cycle.
  - Illegal op goes to DONE with cause 10. Illegal means: op_load & op_store both high; load funct3 in {011,110,111}; store funct3 > 010.
  - Misaligned op goes to DONE with cause 01. Misaligned means: word access with addr[1:0] != 0; half access with addr[0] != 0.
  - Otherwise go to REQ.
  - A faulted op never asserts mem_req.
- REQ:
  - mem_req = 1; mem_addr, mem_we, mem_be, mem_wdata held stable until mem_ready is sampled high.
  - Store with mem_ready goes to DONE.
  - Load with mem_ready goes to WAIT. If mem_rvalid is also high in that cycle, capture rdata and go directly to DONE.
- WAIT: on mem_rvalid, capture mem_rdata and go to DONE. mem_rvalid outside REQ/WAIT is ignored.
- Timeout:
  - The counter clears on entry to REQ and on entry to WAIT, and increments every cycle spent there.
  - When it reaches TIMEOUT-1 with no handshake, go to DONE with cause 11 and load_result 0.
  - mem_req deasserts on that transition.
- DONE:
  - done = 1 for exactly one cycle; fault and fault_cause are valid only here; stall = 0.
  - Next state is IDLE.
  - A new op may be accepted no earlier than the cycle after DONE.
- stall = 1 in the accept cycle and in REQ and WAIT; 0 in DONE and in idle with no op.
- Byte enables:
  - sb: 0001 << addr[1:0]
  - sh: 0011 << {addr[1],1'b0}
  - sw: 1111
  - loads drive mem_be = 1111.
- Write data:
  - sb: {4{store_data[7:0]}}
  - sh: {2{store_data[15:0]}}
  - sw: store_data
- Load extraction (lane selected by registered addr[1:0]):
  - lb: byte sign-extended; lbu: byte zero-extended.
  - lh: half sign-extended; lhu: half zero-extended.
  - lw: full word.
- Latency with zero-wait memory (ready and rvalid high immediately):
  - load: accept N, REQ N+1, DONE N+2.
  - store: accept N, REQ N+1, DONE N+2.
  - fault: accept N, DONE N+1.

Test Plan:
- lb addr=0x1003, rdata=0x80FF_1234, ready/rvalid immediate -> mem_addr 0x1000, be 1111, done at N+2, load_result 0xFFFF_FF80, fault 0.
- lhu addr=0x2002, rdata=0x8001_0000, rvalid 3 cycles after ready -> stall held through WAIT, load_result 0x0000_8001.
- sh addr=0x10, store_data=0xDEAD_BEEF, ready delayed 2 cycles -> mem_be 0011, wdata 0xBEEF_BEEF, mem_we 1, signals stable while waiting, done after handshake.
- lw addr=0x6 -> no mem_req ever, done at N+1 with fault 1 / cause 01; op_load=op_store=1 -> cause 10.
- Load with mem_ready held high and mem_rvalid never arriving (TIMEOUT=16) -> done with cause 11, load_result 0, mem_req low after the fault, FSM returns to IDLE.
- Drop rst_n during WAIT -> mem_req/stall 0 immediately, no done; after release, a sw addr=0x20 data=0x12345678 completes normally with be 1111.
